// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

  // Number of router output ports; addresses 0..NUM_PORTS-1 are deliverable.
  localparam int unsigned NUM_PORTS = 3;

  // Address width of the header address field.
  localparam int unsigned ADDR_W = 2;

  // Header address that names no port; packets carrying it are dropped.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Packet-sequencing states, 3-bit binary encoding with decode-address at zero.
  typedef enum logic [2:0] {
    ST_DA  = 3'd0,  // decode address
    ST_LFD = 3'd1,  // load first data (header)
    ST_LD  = 3'd2,  // load payload
    ST_FFS = 3'd3,  // fifo full stall
    ST_LAF = 3'd4,  // load after full
    ST_LP  = 3'd5,  // load parity
    ST_CPE = 3'd6,  // check parity error
    ST_WTE = 3'd7   // wait till empty
  } state_e;

  // True when the address selects a real output port.
  function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

  // Pick the per-port flag belonging to an address; the invalid address reads 0
  // so callers never index past the top port.
  function automatic logic port_flag(input logic [NUM_PORTS-1:0] flags,
                                     input logic [ADDR_W-1:0]    addr);
    logic flag;
    case (addr)
      2'd0:    flag = flags[0];
      2'd1:    flag = flags[1];
      2'd2:    flag = flags[2];
      default: flag = 1'b0;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing controller for the 1x3 router: walks each packet through
// header decode, payload load, full stall, parity load and parity check, and
// emits Moore strobes for the register block and synchroniser.
module router_fsm_ctrl
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;

  // A header in DA is accepted only when valid and addressed to a real port.
  logic header_ok;
  // Read-timeout reset belonging to the latched destination port.
  logic timeout_hit;

  assign header_ok   = pkt_valid && addr_is_valid(data_in);
  assign timeout_hit = addr_is_valid(addr_q) && port_flag(soft_reset, addr_q);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of process ordering.
    if (rst) begin
      state_q <= ST_DA;
    end else begin
      state_q <= state_d;
    end
  end

  // Destination address latch; survives soft reset and is replaced by the
  // next accepted header.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= ADDR_INVALID;
    end else if (state_q == ST_DA && header_ok) begin
      addr_q <= data_in;
    end
  end

  // Next-state logic: soft reset of the addressed port overrides every state.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_DA;
    end else begin
      unique case (state_q)
        ST_DA: begin
          if (header_ok) begin
            state_d = port_flag(fifo_empty, data_in) ? ST_LFD : ST_WTE;
          end
        end
        ST_LFD: state_d = ST_LD;
        ST_LD: begin
          if (fifo_full) begin
            state_d = ST_FFS;
          end else if (!pkt_valid) begin
            state_d = ST_LP;
          end
        end
        ST_FFS: begin
          if (!fifo_full) begin
            state_d = ST_LAF;
          end
        end
        ST_LAF: begin
          if (parity_done) begin
            state_d = ST_DA;
          end else if (low_pkt_valid) begin
            state_d = ST_LP;
          end else begin
            state_d = ST_LD;
          end
        end
        ST_LP:  state_d = ST_CPE;
        ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;
        ST_WTE: begin
          if (port_flag(fifo_empty, addr_q)) begin
            state_d = ST_LFD;
          end
        end
        default: state_d = ST_DA;
      endcase
    end
  end

  // Moore output decode; busy is released only while decoding or loading payload.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      ST_DA: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      ST_LFD: lfd_state = 1'b1;
      ST_LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      ST_FFS: full_state = 1'b1;
      ST_LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      ST_LP:  write_enb_reg = 1'b1;
      ST_CPE: rst_int_reg   = 1'b1;
      ST_WTE: busy          = 1'b1;
      default: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/router_fsm_ctrl.md
# router_fsm_ctrl

Packet-sequencing controller for the 1x3 router. It tracks each incoming packet through header decode, payload load, FIFO-full stall, parity load and parity check. It drives the strobes that steer the register block and the synchroniser: `detect_add`, `write_enb_reg`, `lfd_state`, `ld_state`, `laf_state`, `full_state` and `rst_int_reg`, and it raises `busy` toward the source.

## Interface
- No parameters. Address width is fixed at 2 bits and there are 3 output ports.
- `clk`  in  1  Router clock. All state changes on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `pkt_valid`  in  1  Source is driving packet bytes (header/payload). Deasserts for the parity byte.
- `data_in`  in  2  Header address bits [1:0]. Sampled only in DECODE_ADDRESS.
- `fifo_full`  in  1  Full flag of the currently addressed FIFO, from the synchroniser.
- `fifo_empty`  in  3  Per-port FIFO empty flags.
- `soft_reset`  in  3  Per-port 30-cycle read-timeout resets, from the synchroniser.
- `parity_done`  in  1  Register block has captured the parity byte.
- `low_pkt_valid`  in  1  Register block saw `pkt_valid` fall while stalled.
- `busy`  out  1  Source must hold the current byte.
- `detect_add`  out  1  Header decode strobe.
- `lfd_state`  out  1  Load-first-data (header) strobe.
- `ld_state`  out  1  Payload load strobe.
- `laf_state`  out  1  Load-after-full strobe.
- `full_state`  out  1  FIFO-full stall strobe.
- `write_enb_reg`  out  1  Write enable toward the synchroniser.
- `rst_int_reg`  out  1  Clear internal parity/error registers.

## Operation
- States: DA (decode address), LFD, LD, FFS (fifo full), LAF, LP (load parity), CPE (check parity error), WTE (wait till empty).
- `addr_q` (2 bits) is a latched address. It loads `data_in` in DA when `pkt_valid` and `data_in != 2'b11`.
- The outputs are a Moore decode of state:
  - `detect_add`=DA, `lfd_state`=LFD, `ld_state`=LD, `laf_state`=LAF, `full_state`=FFS, `rst_int_reg`=CPE.
  - `write_enb_reg`=LD|LAF|LP.
  - `busy`=LFD|FFS|LAF|LP|CPE|WTE. `busy` is low only in DA and LD.
- Transition priority:
  - `rst` has highest priority.
  - Next is `soft_reset[addr_q]` with `addr_q != 2'b11`: from any state go to DA.
  - Per-state rules apply only after those two.
- DA:
  - `pkt_valid` && `data_in != 3` && `fifo_empty[data_in]`: go to LFD.
  - Same address conditions but `!fifo_empty[data_in]`: go to WTE.
  - Otherwise stay in DA. Address 3 is dropped.
- LFD: go to LD unconditionally.
- LD: `fifo_full` goes to FFS; else `!pkt_valid` goes to LP; else stay. `fifo_full` wins over `!pkt_valid`.
- FFS: `!fifo_full` goes to LAF; else stay.
- LAF:
  - `parity_done` goes to DA.
  - Else `low_pkt_valid` goes to LP.
  - Else go to LD.
- LP: go to CPE.
- CPE: `fifo_full` goes to FFS; else go to DA.
- WTE: `fifo_empty[addr_q]` goes to LFD; else stay.
- Illegal state encodings recover to DA on the next edge.

## Timing
- Reset: state=DA and `addr_q`=2'b11 on the first edge with `rst`=1. After that edge, `detect_add`=1 and all other outputs are 0.
- Outputs change one cycle after the qualifying input edge. There is no combinational input-to-output path.
- Minimum header-to-payload latency: DA at cycle 0, LFD at 1, LD at 2.
- Minimum parity latency: LD at cycle n, LP at n+1, CPE at n+2, DA at n+3.
- Soft reset is honoured in the same cycle it is sampled, including mid-stall (FFS) and mid-wait (WTE).
- `addr_q` is not cleared by `soft_reset`. It is overwritten by the next valid header.

## Structure
- `router_pkg` holds:
  - the state enum (3-bit binary encoding, DA=0),
  - `ADDR_INVALID`=2'b11,
  - `NUM_PORTS`=3.
- No sub-module. The design is one state register, the `addr_q` register, a next-state block and an output decode.

## Test plan
- Reset: `rst`=1 for 2 cycles, then low. Expect `detect_add`=1, `busy`=0, all other strobes 0, state DA.
- Normal packet: `data_in`=2'b01, `fifo_empty`=3'b111, `pkt_valid` high for 4 cycles then low.
  - Expect DA, LFD, LD×3, LP, CPE, DA.
  - Expect `write_enb_reg` high in LD and LP.
  - Expect `rst_int_reg` pulsed for 1 cycle.
- Busy destination: `data_in`=2'b10 with `fifo_empty`=3'b011.
  - Expect WTE with `busy`=1.
  - Raise `fifo_empty[2]`. Expect LFD on the next edge.
- Full stall: `fifo_full`=1 during LD. Expect FFS with `busy`=1.
  - Drop `fifo_full` with `low_pkt_valid`=1. Expect LAF, then LP.
  - Repeat with `parity_done`=1 in LAF. Expect LAF, then DA.
- Timeout: in WTE with `addr_q`=0, pulse `soft_reset`=3'b001. Expect DA next cycle.
  - A `soft_reset`=3'b100 pulse in the same state is ignored.
- Invalid address: `pkt_valid`=1 with `data_in`=2'b11 for 5 cycles. Expect state to remain DA and `addr_q`=2'b11 unchanged.
